mac_rx_capture: RTL and testbench

Consumer end of the tri-mode MAC receive FIFO interface. Requests words from the MAC, frames them by SOP/EOP into a circular word buffer, and queues one descriptor per good packet (start address, byte length) for the downstream AXI-side reader. Buffer space is freed when the reader acknowledges the descriptor. Sits between the MAC RX FIFO and the AXI-lite read buffer logic.

---
 rtl/mac_rx_pkg.sv | 31 +++
 rtl/mac_rx_desc_fifo.sv | 57 +++++
 rtl/mac_rx_capture.sv | 165 ++++++++++++++++
 tb/tb_mac_rx_capture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_rx_pkg.sv
// Shared types for the MAC receive capture path: FSM states, the queued
// packet descriptor, and the EOP byte-length calculation.
package mac_rx_pkg;

    // Widest supported buffer address; descriptor fields are sized to this
    // so a single struct serves every ADDR_W below it.
    localparam int MAX_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        PACKET,
        DROP
    } rx_state_t;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;     // first word of the packet
        logic [MAX_ADDR_W+1:0] len;      // length in bytes
        logic [MAX_ADDR_W:0]   end_ptr;  // write pointer just past the packet
    } desc_t;

    // bytes = 4*(words-1) + tail, where ben==0 means a full 4-byte tail
    function automatic logic [MAX_ADDR_W+1:0] byte_len(input logic [MAX_ADDR_W:0] words,
                                                       input logic [1:0]          ben);
        logic [MAX_ADDR_W+1:0] body;
        logic [MAX_ADDR_W+1:0] tail;
        body = (MAX_ADDR_W+2)'(words) - 1'b1;
        tail = (ben == 2'd0) ? (MAX_ADDR_W+2)'(4) : (MAX_ADDR_W+2)'(ben);
        return (body << 2) + tail;
    endfunction

endpackage

// File: rtl/mac_rx_desc_fifo.sv
// Descriptor queue between capture and the downstream reader.
// First-word-fall-through: dout shows the head entry whenever !empty.
module mac_rx_desc_fifo
    import mac_rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  desc_t din,
    input  logic  pop,
    output desc_t dout,
    output logic  full,
    output logic  empty
);

    localparam int IDX_W = $clog2(DEPTH);

    desc_t            mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (IDX_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_idx];

    // entry storage, no reset needed: contents are qualified by count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

    // ring indices and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_idx <= wr_idx + 1'b1;
            if (do_pop)  rd_idx <= rd_idx + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_rx_capture.sv
// MAC RX FIFO consumer: frames SOP/EOP words into a circular buffer and
// queues one descriptor per good packet; space is freed on descriptor ack.
module mac_rx_capture
    import mac_rx_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int DESC_DEPTH = 8,
    parameter int SKID       = 4
) (
    input  logic              mac_clk_i,
    input  logic              mac_rst_i,
    input  logic [31:0]       mac_rxd_i,
    input  logic [1:0]        mac_ben_i,
    input  logic              mac_rxda_i,
    input  logic              mac_rxsop_i,
    input  logic              mac_rxeop_i,
    input  logic              mac_rxdv_i,
    output logic              mac_rxrqrd_o,
    output logic              desc_valid_o,
    input  logic              desc_ready_i,
    output logic [ADDR_W-1:0] desc_addr_o,
    output logic [ADDR_W+1:0] desc_len_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [31:0]       rd_data_o,
    output logic [15:0]       drop_cnt_o
);

    localparam int               PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] CAP   = {1'b1, {ADDR_W{1'b0}}};

    logic [31:0]      buf_mem [2**ADDR_W];
    rx_state_t        state, state_n;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
    logic [PTR_W-1:0] pkt_start;
    logic [PTR_W-1:0] rel_ptr;
    logic [PTR_W-1:0] free_words;
    logic [PTR_W-1:0] wa;
    logic [PTR_W-1:0] wa_next;
    logic [PTR_W-1:0] used_at;
    logic [PTR_W-1:0] pkt_words;
    logic             room;
    logic             mem_we;
    logic             push;
    logic             commit;
    logic             drop_inc;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    desc_t            desc_in;
    desc_t            head;
    logic             unused_hi;

    // An SOP always restarts at the committed start, which also abandons any
    // open packet; pkt_start equals wr_ptr whenever no packet is open.
    assign wa         = mac_rxsop_i ? pkt_start : wr_ptr;
    assign wa_next    = wa + 1'b1;
    assign used_at    = wa - rel_ptr;
    assign room       = !used_at[ADDR_W];
    assign pkt_words  = wa_next - pkt_start;
    assign free_words = CAP - (wr_ptr - rel_ptr);

    assign desc_in = '{addr:    MAX_ADDR_W'(pkt_start[ADDR_W-1:0]),
                       len:     byte_len((MAX_ADDR_W+1)'(pkt_words), mac_ben_i),
                       end_ptr: (MAX_ADDR_W+1)'(wa_next)};

    mac_rx_desc_fifo #(
        .DEPTH (DESC_DEPTH)
    ) u_desc_fifo (
        .clk   (mac_clk_i),
        .rst   (mac_rst_i),
        .push  (push),
        .din   (desc_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign desc_valid_o = !fifo_empty;
    assign pop          = desc_valid_o && desc_ready_i;
    assign desc_addr_o  = desc_valid_o ? head.addr[ADDR_W-1:0] : '0;
    assign desc_len_o   = desc_valid_o ? head.len[ADDR_W+1:0]  : '0;

    // Upper descriptor bits exist only so one struct serves every ADDR_W.
    assign unused_hi = ^{head.addr[MAX_ADDR_W-1:ADDR_W],
                         head.len[MAX_ADDR_W+1:ADDR_W+2],
                         head.end_ptr[MAX_ADDR_W:ADDR_W+1]};

    // FSM state register
    always_ff @(posedge mac_clk_i or posedge mac_rst_i) begin
        if (mac_rst_i) state <= IDLE;
        else           state <= state_n;
    end

    // framing: next state, buffer write, descriptor push and drop decisions
    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        mem_we   = 1'b0;
        push     = 1'b0;
        commit   = 1'b0;
        drop_inc = 1'b0;
        case (state)
            IDLE, PACKET: begin
                if (mac_rxdv_i && (state == PACKET || mac_rxsop_i)) begin
                    if (state == PACKET && mac_rxsop_i) drop_inc = 1'b1;
                    if (!room) begin
                        drop_inc = 1'b1;
                        wr_ptr_n = pkt_start;
                        state_n  = mac_rxeop_i ? IDLE : DROP;
                    end else begin
                        mem_we = 1'b1;
                        if (!mac_rxeop_i) begin
                            wr_ptr_n = wa_next;
                            state_n  = PACKET;
                        end else if (fifo_full) begin
                            drop_inc = 1'b1;
                            wr_ptr_n = pkt_start;
                            state_n  = IDLE;
                        end else begin
                            push     = 1'b1;
                            commit   = 1'b1;
                            wr_ptr_n = wa_next;
                            state_n  = IDLE;
                        end
                    end
                end
            end
            DROP: begin
                if (mac_rxdv_i && mac_rxeop_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // pointers, drop counter and MAC read request
    always_ff @(posedge mac_clk_i or posedge mac_rst_i) begin
        if (mac_rst_i) begin
            wr_ptr       <= '0;
            pkt_start    <= '0;
            rel_ptr      <= '0;
            drop_cnt_o   <= '0;
            mac_rxrqrd_o <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_n;
            if (commit) pkt_start <= wa_next;
            if (pop)    rel_ptr   <= head.end_ptr[ADDR_W:0];
            if (drop_inc && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
            mac_rxrqrd_o <= mac_rxda_i && !fifo_full &&
                            ((free_words > PTR_W'(SKID)) || (state == DROP));
        end
    end

    // packet buffer write port
    always_ff @(posedge mac_clk_i) begin
        if (mem_we) buf_mem[wa[ADDR_W-1:0]] <= mac_rxd_i;
    end

    // packet buffer read port, one-cycle latency
    always_ff @(posedge mac_clk_i or posedge mac_rst_i) begin
        if (mac_rst_i) rd_data_o <= '0;
        else           rd_data_o <= buf_mem[rd_addr_i];
    end

endmodule

// File: tb/tb_mac_rx_capture.sv
// Directed bench for mac_rx_capture on a 16-word buffer with a 4-entry
// descriptor queue: framing table, then drop, reset, wrap and queue-full runs.
module tb_mac_rx_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rxd = '0;
    logic [1:0]  ben = '0;
    logic        rxda = 1'b0;
    logic        sop = 1'b0;
    logic        eop = 1'b0;
    logic        dv = 1'b0;
    logic        rqrd;
    logic        dvalid;
    logic        dready = 1'b0;
    logic [3:0]  daddr;
    logic [5:0]  dlen;
    logic [3:0]  ra = '0;
    logic [31:0] rdata;
    logic [15:0] dcnt;

    int checks = 0;
    int errors = 0;

    mac_rx_capture #(
        .ADDR_W     (4),
        .DESC_DEPTH (4),
        .SKID       (4)
    ) dut (
        .mac_clk_i    (clk),
        .mac_rst_i    (rst),
        .mac_rxd_i    (rxd),
        .mac_ben_i    (ben),
        .mac_rxda_i   (rxda),
        .mac_rxsop_i  (sop),
        .mac_rxeop_i  (eop),
        .mac_rxdv_i   (dv),
        .mac_rxrqrd_o (rqrd),
        .desc_valid_o (dvalid),
        .desc_ready_i (dready),
        .desc_addr_o  (daddr),
        .desc_len_o   (dlen),
        .rd_addr_i    (ra),
        .rd_data_o    (rdata),
        .drop_cnt_o   (dcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv, sop, eop;
        logic [1:0]  ben;
        logic [31:0] d;
        logic        rdy;
        logic [3:0]  ra;
        logic        e_valid;
        logic [3:0]  e_addr;
        logic [5:0]  e_len;
        logic [15:0] e_drop;
        logic        chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic v, input logic s, input logic e, input logic [1:0] b,
                                input logic [31:0] d, input logic r, input logic [3:0] a,
                                input logic ev, input logic [3:0] ea, input logic [5:0] el,
                                input logic [15:0] ed, input logic cr, input logic [31:0] er);
        vec_t t;
        t.dv = v; t.sop = s; t.eop = e; t.ben = b; t.d = d; t.rdy = r; t.ra = a;
        t.e_valid = ev; t.e_addr = ea; t.e_len = el; t.e_drop = ed;
        t.chk_rd = cr; t.e_rd = er;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic s, input logic e, input logic [1:0] b, input logic [31:0] d);
        dv = 1'b1; sop = s; eop = e; ben = b; rxd = d;
        tick();
        dv = 1'b0; sop = 1'b0; eop = 1'b0; ben = '0;
    endtask

    task automatic release_one();
        dready = 1'b1;
        tick();
        dready = 1'b0;
    endtask

    task automatic chk_desc(input string name, input logic ev, input logic [3:0] ea, input logic [5:0] el);
        chk({name, "_valid"}, 32'(dvalid), 32'(ev));
        if (ev) begin
            chk({name, "_addr"}, 32'(daddr), 32'(ea));
            chk({name, "_len"}, 32'(dlen), 32'(el));
        end
    endtask

    initial begin
        // 3-word packet, ben=2 on EOP, then read back
        tbl[0]  = mk(1,1,0,0,32'hA000_0000, 0,0, 0,0,0,0,  0,0);
        tbl[1]  = mk(1,0,0,0,32'hA000_0001, 0,0, 0,0,0,0,  0,0);
        tbl[2]  = mk(1,0,1,2,32'hA000_0002, 0,0, 1,0,10,0, 0,0);
        tbl[3]  = mk(0,0,0,0,32'h0,         0,0, 1,0,10,0, 1,32'hA000_0000);
        tbl[4]  = mk(0,0,0,0,32'h0,         0,1, 1,0,10,0, 1,32'hA000_0001);
        tbl[5]  = mk(0,0,0,0,32'h0,         1,2, 0,0,0,0,  1,32'hA000_0002);
        // two back-to-back single-word packets
        tbl[6]  = mk(1,1,1,1,32'hB000_0003, 0,0, 1,3,1,0,  0,0);
        tbl[7]  = mk(1,1,1,0,32'hB000_0004, 0,0, 1,3,1,0,  0,0);
        tbl[8]  = mk(0,0,0,0,32'h0,         1,0, 1,4,4,0,  0,0);
        tbl[9]  = mk(0,0,0,0,32'h0,         1,0, 0,0,0,0,  0,0);
        // open packet abandoned by a new SOP
        tbl[10] = mk(1,1,0,0,32'hC000_0005, 0,0, 0,0,0,0,  0,0);
        tbl[11] = mk(1,0,0,0,32'hC000_0006, 0,0, 0,0,0,0,  0,0);
        tbl[12] = mk(1,1,0,0,32'hC000_0007, 0,0, 0,0,0,1,  0,0);
        tbl[13] = mk(1,0,1,3,32'hC000_0008, 0,0, 1,5,7,1,  0,0);
        tbl[14] = mk(0,0,0,0,32'h0,         0,5, 1,5,7,1,  1,32'hC000_0007);
        tbl[15] = mk(0,0,0,0,32'h0,         1,6, 0,0,0,1,  1,32'hC000_0008);
        // stray non-SOP word in IDLE is discarded
        tbl[16] = mk(1,0,0,0,32'hD000_0000, 0,0, 0,0,0,1,  0,0);
        tbl[17] = mk(1,1,1,0,32'hD000_0007, 0,0, 1,7,4,1,  0,0);
        tbl[18] = mk(0,0,0,0,32'h0,         1,7, 0,0,0,1,  1,32'hD000_0007);

        // reset values
        #1;
        chk("rst_rqrd",  32'(rqrd),   0);
        chk("rst_valid", 32'(dvalid), 0);
        chk("rst_addr",  32'(daddr),  0);
        chk("rst_len",   32'(dlen),   0);
        chk("rst_rdata", rdata,       0);
        chk("rst_drop",  32'(dcnt),   0);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            dv = tbl[i].dv; sop = tbl[i].sop; eop = tbl[i].eop; ben = tbl[i].ben;
            rxd = tbl[i].d; dready = tbl[i].rdy; ra = tbl[i].ra;
            tick();
            chk_desc($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_addr, tbl[i].e_len);
            chk($sformatf("vec%0d_drop", i), 32'(dcnt), 32'(tbl[i].e_drop));
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rd);
        end
        dv = 1'b0; sop = 1'b0; eop = 1'b0; ben = '0; dready = 1'b0;

        // oversize packet: 17th word finds no space, packet dropped
        rxda = 1'b1;
        tick();
        tick();
        chk("drop_rqrd_idle", 32'(rqrd), 1);
        for (int k = 1; k <= 20; k++) begin
            word(k == 1, k == 20, 2'd0, 32'hE000_0000 + k);
            if (k == 13) chk("drop_rqrd_skid", 32'(rqrd), 0);
            if (k == 17) begin
                chk("drop_cnt_enter", 32'(dcnt), 2);
                chk("drop_valid_enter", 32'(dvalid), 0);
            end
            if (k >= 18) chk($sformatf("drop_rqrd_%0d", k), 32'(rqrd), 1);
        end
        chk("drop_valid_end", 32'(dvalid), 0);
        chk("drop_cnt_end", 32'(dcnt), 2);
        word(1'b1, 1'b1, 2'd3, 32'h5A5A_0008);
        chk_desc("drop_after", 1'b1, 4'd8, 6'd3);
        release_one();
        chk("drop_after_rel", 32'(dvalid), 0);

        // reset in the middle of a packet with a descriptor pending
        word(1'b1, 1'b1, 2'd0, 32'h5A5A_0009);
        chk_desc("pre_rst", 1'b1, 4'd9, 6'd4);
        word(1'b1, 1'b0, 2'd0, 32'hF000_000A);
        word(1'b0, 1'b0, 2'd0, 32'hF000_000B);
        ra = 4'd8;
        tick();
        chk("pre_rst_rdata", rdata, 32'h5A5A_0008);
        chk("pre_rst_rqrd", 32'(rqrd), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rqrd",  32'(rqrd),   0);
        chk("mid_rst_valid", 32'(dvalid), 0);
        chk("mid_rst_addr",  32'(daddr),  0);
        chk("mid_rst_len",   32'(dlen),   0);
        chk("mid_rst_rdata", rdata,       0);
        chk("mid_rst_drop",  32'(dcnt),   0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 14 words then a 5-word packet that wraps across address 0
        word(1'b1, 1'b1, 2'd2, 32'h1111_0000);
        chk_desc("post_rst", 1'b1, 4'd0, 6'd2);
        for (int k = 1; k <= 13; k++) word(k == 1, k == 13, 2'd0, 32'h2222_0000 + k);
        release_one();
        chk_desc("wrap_p1", 1'b1, 4'd1, 6'd52);
        release_one();
        chk("wrap_empty", 32'(dvalid), 0);
        for (int k = 0; k < 5; k++) word(k == 0, k == 4, 2'd1, 32'h3333_0000 + k);
        chk_desc("wrap_p2", 1'b1, 4'd14, 6'd17);
        for (int i = 0; i < 5; i++) begin
            ra = 4'(14 + i);
            tick();
            chk($sformatf("wrap_rd%0d", i), rdata, 32'h3333_0000 + i);
        end
        release_one();
        chk("wrap_rel", 32'(dvalid), 0);

        // descriptor queue full: request drops, forced packet is dropped
        for (int k = 0; k < 4; k++) word(1'b1, 1'b1, 2'd0, 32'h4444_0000 + k);
        chk_desc("full_head", 1'b1, 4'd3, 6'd4);
        tick();
        chk("full_rqrd", 32'(rqrd), 0);
        word(1'b1, 1'b1, 2'd2, 32'h4444_00FF);
        chk("full_drop", 32'(dcnt), 1);
        chk_desc("full_head_kept", 1'b1, 4'd3, 6'd4);
        for (int k = 1; k < 4; k++) begin
            release_one();
            chk_desc($sformatf("full_rel%0d", k), 1'b1, 4'(3 + k), 6'd4);
        end
        release_one();
        chk("full_drained", 32'(dvalid), 0);
        tick();
        tick();
        chk("rqrd_resume", 32'(rqrd), 1);
        rxda = 1'b0;
        tick();
        chk("rqrd_no_data", 32'(rqrd), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
